// File: rtl/input_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : input_pkg                                                        |
// | Shared reader FSM encoding and default bus widths.                         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package input_pkg;
  localparam int c_DEF_ADDR_W = 16;
  localparam int c_DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;
endpackage
`default_nettype wire

// File: rtl/bram_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : bram_stream_reader_if                                          |
// | Valid/ready byte stream carrying data and an end-of-burst marker.          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface bram_stream_reader_if
  import input_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : stream_skid_fifo                                                  |
// | Two-entry FIFO; the writer guarantees it never pushes into a full FIFO.    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module stream_skid_fifo #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] r_entry [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_entry[r_wr_ptr] <= push_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is read directly, so it stays put for as long as it is not popped.
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_entry[r_rd_ptr];
  assign count     = r_count;
endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bram_stream_reader                                                |
// | Streams a burst of bytes out of a 1-cycle-latency memory with backpressure.|
// | Option : BRAM_RD_CHECKSUM_EN adds a 16-bit running checksum output.        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module bram_stream_reader
  import input_pkg::*;
#(
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  bram_stream_reader_if.master m,
  output logic                busy,
  output logic                done
`ifdef BRAM_RD_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0] r_len_m1;
  logic              r_pend;
  logic              r_pend_last;
  logic              r_done;

  logic              w_accept;
  logic              w_pop;
  logic              w_last_hs;
  logic              w_issue;
  logic              w_final_issue;
  logic [2:0]        w_credit;
  logic              w_fifo_valid;
  logic [DATA_W:0]   w_fifo_out;
  logic [1:0]        w_fifo_count;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_pop     = m.m_valid && m.m_ready;
  assign w_last_hs = w_pop && m.m_last;

  // Entries still owed to the FIFO after this cycle's pop; a new read fits if below 2.
  assign w_credit      = {1'b0, w_fifo_count} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue       = (r_state == ST_RUN) && (w_credit < 3'd2);
  assign w_final_issue = w_issue && (r_issue_cnt == r_len_m1);

  assign mem_addr = w_issue ? r_next_addr : r_last_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && (length != '0)) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_final_issue)           w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_hs)               w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_issue_cnt <= '0;
      r_len_m1    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_issue;
      r_pend_last <= w_final_issue;
      r_done      <= (w_accept && (length == '0)) || ((r_state == ST_DRAIN) && w_last_hs);
      if (w_accept) begin
        r_next_addr <= base_addr;
        r_len_m1    <= length - ADDR_W'(1);
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_next_addr <= r_next_addr + ADDR_W'(1);
        r_last_addr <= r_next_addr;
        r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
      end
    end
  end

  stream_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_pend),
    .push_data ({r_pend_last, mem_data}),
    .pop       (w_pop),
    .out_valid (w_fifo_valid),
    .out_data  (w_fifo_out),
    .count     (w_fifo_count)
  );

  assign m.m_valid = w_fifo_valid;
  assign m.m_data  = w_fifo_out[DATA_W-1:0];
  assign m.m_last  = w_fifo_valid && w_fifo_out[DATA_W];

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

`ifdef BRAM_RD_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 16'd0;
    end else if (w_accept) begin
      r_checksum <= 16'd0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + 16'(m.m_data);
    end
  end

  assign checksum = r_checksum;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bram_stream_reader                                             |
// | Directed bench for bram_stream_reader with a registered-read memory model. |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_bram_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
`ifdef BRAM_RD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  bram_stream_reader_if #(.DATA_W(8)) s_if ();

  bram_stream_reader #(
    .ADDR_W (16),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .m         (s_if),
    .busy      (busy),
    .done      (done)
`ifdef BRAM_RD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns the low address byte one cycle after the address is seen.
  always @(posedge clk) mem_data <= mem_addr[7:0];

  int n_cyc = 0;
  always @(posedge clk) n_cyc <= n_cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          t0 = 0;
  logic [7:0]  got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  logic [15:0] addr_q[$];
  int          valid_cnt = 0;
  int          done_cnt  = 0;
  int          done_cyc  = -1;
  logic        done_busy = 1'b0;
  logic        p_stall   = 1'b0;
  logic [7:0]  p_data    = 8'h00;
  logic        p_last    = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (p_stall) begin
        check("stall_valid", 32'(s_if.m_valid), 32'd1);
        check("stall_data", 32'(s_if.m_data), 32'(p_data));
        check("stall_last", 32'(s_if.m_last), 32'(p_last));
      end
      if (s_if.m_valid && s_if.m_ready) begin
        got_data.push_back(s_if.m_data);
        got_last.push_back(s_if.m_last);
        got_cyc.push_back(n_cyc - t0);
      end
      if (s_if.m_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc  = n_cyc - t0;
        done_busy = busy;
      end
      addr_q.push_back(mem_addr);
    end
    p_stall = rst_n && s_if.m_valid && !s_if.m_ready;
    p_data  = s_if.m_data;
    p_last  = s_if.m_last;
  end

  // Returns one cycle after start was sampled, i.e. at the start of relative cycle 0.
  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; s_if.m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = n_cyc;
    got_data.delete(); got_last.delete(); got_cyc.delete(); addr_q.delete();
    valid_cnt = 0; done_cnt = 0; done_cyc = -1; done_busy = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle, input int glitch_k);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      s_if.m_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      start = (k == glitch_k);
      if (k == glitch_k) begin
        base_addr = 16'h0200;
        length    = 16'd2;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic verify_stream(input string tag, input logic [15:0] b, input int len);
    int          bad_d = 0;
    int          bad_l = 0;
    logic [15:0] a;
    check({tag, "_count"}, 32'(got_data.size()), 32'(len));
    for (int i = 0; i < got_data.size(); i++) begin
      a = b + 16'(i);
      if (len <= 16) begin
        check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(a[7:0]));
        check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == len - 1));
      end else begin
        if (got_data[i] !== a[7:0]) bad_d++;
        if (got_last[i] !== (i == len - 1)) bad_l++;
      end
    end
    if (len > 16) begin
      check({tag, "_bad_data"}, 32'(bad_d), 32'd0);
      check({tag, "_bad_last"}, 32'(bad_l), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; length = 16'h0; s_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_valid", 32'(s_if.m_valid), 32'h0);
    check("rst_last", 32'(s_if.m_last), 32'h0);
    check("rst_data", 32'(s_if.m_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Basic burst at full rate: bytes in cycles 2..5, done in cycle 6.
    do_start(16'h0010, 16'd4);
    run_until_done(50, 1'b0, 0);
    verify_stream("b4", 16'h0010, 4);
    for (int i = 0; i < 4 && i < got_cyc.size(); i++)
      check($sformatf("b4_cyc%0d", i), 32'(got_cyc[i]), 32'(2 + i));
    check("b4_done_cyc", 32'(done_cyc), 32'd6);
    check("b4_busy_at_done", 32'(done_busy), 32'd0);
    check("b4_addr_hold", 32'(addr_q.size() > 4 ? addr_q[4] : 16'hxxxx), 32'h0013);

    // Address wrap across the top of the space.
    do_start(16'hFFFE, 16'd4);
    run_until_done(50, 1'b0, 0);
    verify_stream("wrap", 16'hFFFE, 4);
    check("wrap_a0", 32'(addr_q.size() > 3 ? addr_q[0] : 16'hxxxx), 32'hFFFE);
    check("wrap_a1", 32'(addr_q.size() > 3 ? addr_q[1] : 16'hxxxx), 32'hFFFF);
    check("wrap_a2", 32'(addr_q.size() > 3 ? addr_q[2] : 16'hxxxx), 32'h0000);
    check("wrap_a3", 32'(addr_q.size() > 3 ? addr_q[3] : 16'hxxxx), 32'h0001);

    // Backpressure 1,0,0,1 with a start pulse that must be ignored mid-burst.
    do_start(16'h0040, 16'd8);
    run_until_done(200, 1'b1, 2);
    s_if.m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    verify_stream("bp", 16'h0040, 8);
    check("bp_done_once", 32'(done_cnt), 32'd1);
    check("bp_idle_after", 32'(busy), 32'd0);

    // Empty burst.
    do_start(16'h0030, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_done_cnt", 32'(done_cnt), 32'd1);
    check("zero_done_cyc", 32'(done_cyc), 32'd0);
    check("zero_valid", 32'(valid_cnt), 32'd0);
    check("zero_busy", 32'(done_busy), 32'd0);

    // Reset in cycle 3 of a 16-byte burst.
    do_start(16'h0120, 16'd16);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(s_if.m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    check("mid_rst_valid", 32'(s_if.m_valid), 32'h0);
    check("mid_rst_last", 32'(s_if.m_last), 32'h0);
    check("mid_rst_data", 32'(s_if.m_data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    do_start(16'h0010, 16'd4);
    run_until_done(50, 1'b0, 0);
    verify_stream("after_rst", 16'h0010, 4);

`ifdef BRAM_RD_CHECKSUM_EN
    do_start(16'h0000, 16'd256);
    run_until_done(400, 1'b0, 0);
    verify_stream("cks", 16'h0000, 256);
    check("cks_value", 32'(checksum), 32'h7F80);
    repeat (3) @(posedge clk);
    #1;
    check("cks_stable", 32'(checksum), 32'h7F80);
`endif

    // Maximum length with wrap: 0x8000 .. 0x7FFE.
    do_start(16'h8000, 16'hFFFF);
    run_until_done(70000, 1'b0, 0);
    verify_stream("max", 16'h8000, 65535);
    check("max_final", 32'(got_data.size() == 65535 ? got_data[65534] : 8'hxx), 32'h00FE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a burst.
REQ-006 SHALL have port base_addr  input  ADDR_W  first address of the burst, sampled with start.
REQ-007 SHALL have port length  input  ADDR_W  byte count, sampled with start; 0 means empty burst.
REQ-008 SHALL have port mem_addr  output  ADDR_W  read address to the downstream-facing memory.
REQ-009 SHALL have port mem_data  input  DATA_W  memory read data, valid exactly 1 cycle after mem_addr.
REQ-010 SHALL have port m_valid  output  1  stream byte available.
REQ-011 SHALL have port m_ready  input  1  consumer accepts byte.
REQ-012 SHALL have port m_data  output  DATA_W  stream byte.
REQ-013 SHALL have port m_last  output  1  marks final byte of burst.
REQ-014 SHALL have port busy  output  1  high from accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse when burst finished.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; start in IDLE with length>0 goes to RUN; start with length==0 pulses done next cycle and stays IDLE.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL issue consecutive addresses base_addr, base_addr+1, ... modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-019 SHALL count issued reads; RUN -> DRAIN after the length-th issue; DRAIN -> IDLE when the last byte handshakes (m_valid&&m_ready&&m_last).
REQ-020 SHALL capture mem_data one cycle after each issue into a 2-entry output FIFO.
REQ-021 SHALL issue a new read only when FIFO occupancy plus in-flight reads < 2, so no data is lost under backpressure.
REQ-022 SHALL hold mem_addr at last issued value when not issuing (memory reads every cycle; stale reads are discarded).
REQ-023 SHALL present m_data/m_last stable while m_valid && !m_ready.
REQ-024 SHALL sustain one byte per cycle when m_ready is held high; first m_valid 2 cycles after start.
REQ-025 SHALL assert m_last only on byte number length.
REQ-026 SHALL pulse done in the cycle after the last handshake; busy falls in the same cycle.
REQ-027 SHALL support length==0xFFFF with correct wrap and count.

Reset
REQ-028 SHALL on rst_n low immediately force: state IDLE, mem_addr 0, m_valid 0, m_last 0, m_data 0, busy 0, done 0, FIFO empty, counters 0.
REQ-029 SHALL abandon any burst on mid-operation reset with no done pulse.

Configuration
REQ-030 With BRAM_RD_CHECKSUM_EN defined SHALL add output checksum[15:0], cleared on accepted start, adding each handshaken byte modulo 2^16, stable after done.
REQ-031 Without BRAM_RD_CHECKSUM_EN SHALL omit the port and adder entirely.

Structure
REQ-032 SHALL place FSM state enum and default ADDR_W/DATA_W constants in shared package input_pkg.
REQ-033 SHALL implement the 2-entry FIFO as sub-module stream_skid_fifo.

Verification
REQ-034 start, base=0x0010, length=4, m_ready=1, mem=addr[7:0] -> bytes 10,11,12,13 on 4 consecutive cycles, m_last on 13, done one cycle later.
REQ-035 base=0xFFFE, length=4 -> mem_addr FFFE,FFFF,0000,0001; bytes FE,FF,00,01.
REQ-036 length=8, m_ready toggling 1,0,0,1 repeating -> all 8 bytes in order, none duplicated or dropped, data stable while stalled.
REQ-037 start with length=0 -> done one cycle later, m_valid never asserted.
REQ-038 rst_n low in cycle 3 of a length=16 burst -> all outputs 0 immediately; new start afterwards completes normally.
REQ-039 BRAM_RD_CHECKSUM_EN, base=0, length=256, mem=addr[7:0] -> checksum=0x7F80.
